dmem_ctrl: RTL and testbench

Load/store sequencer for the MIPS pipeline's byte-sliced data memory: four 512×8 lanes (lane 3 = bits 31:24 … lane 0 = bits 7:0), each with a one-cycle synchronous read and a `valid_out` flag.

- Accepts one MEM-stage load/store at a time over a valid/ready handshake.
- Decodes size and alignment, drives per-lane read/write enables and data, collects the lane valids, and returns a sign- or zero-extended result.
- Sits between the MEM pipeline stage and the four data-memory lanes.

---
 rtl/dmem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Load/store sequencer for a big-endian data memory built from four 512x8 byte lanes.
// Optional feature macro: DMEM_CTRL_ALIGN_CHK_EN (reject misaligned half/word instead of forcing alignment).
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 4,
    parameter int unsigned ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [3:0]        lane_rd_en,
    output logic [3:0]        lane_wr_en,
    output logic [ADDR_W-3:0] lane_addr,
    output logic [31:0]       lane_wdata,
    input  logic [31:0]       lane_rdata,
    input  logic [3:0]        lane_valid,
    output logic              busy
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic              r_we;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [1:0]        r_off;
    logic [3:0]        r_mask;
    logic [3:0]        r_col;
    logic [31:0]       r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [3:0]        r_rd_en;
    logic [3:0]        r_wr_en;
    logic [ADDR_W-3:0] r_lane_addr;
    logic [31:0]       r_lane_wdata;
    logic              r_busy;

    logic [3:0]        w_mask;
    logic [31:0]       w_wdata;
    logic              w_bad;
    logic [3:0]        w_col_next;
    logic [31:0]       w_data_next;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    // Request decode: lane mask (big-endian, offset b -> lane 3-b) and replicated store data.
    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = '0;
        case (req_size)
            2'b00: begin
                w_mask  = 4'b1000 >> req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_mask  = req_addr[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_mask  = 4'b1111;
                w_wdata = req_wdata;
            end
            default: begin
                w_mask  = 4'b0000;
                w_wdata = '0;
            end
        endcase

        w_bad = (req_size == 2'b11);
`ifdef DMEM_CTRL_ALIGN_CHK_EN
        if ((req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
            (req_size == 2'b01 && req_addr[0])) begin
            w_bad = 1'b1;
        end
`else
        w_bad = w_bad;
`endif
    end

    // Lane collection: new bytes merge with those latched on earlier WAIT cycles.
    always_comb begin
        w_col_next  = r_col | (lane_valid & r_mask);
        w_data_next = r_data;
        for (int unsigned k = 0; k < 4; k++) begin
            if (lane_valid[k] && r_mask[k]) begin
                w_data_next[8*k +: 8] = lane_rdata[8*k +: 8];
            end
        end

        w_byte = '0;
        case (r_off)
            2'b00:   w_byte = w_data_next[31:24];
            2'b01:   w_byte = w_data_next[23:16];
            2'b10:   w_byte = w_data_next[15:8];
            default: w_byte = w_data_next[7:0];
        endcase
        w_half = r_off[1] ? w_data_next[15:0] : w_data_next[31:16];

        case (r_size)
            2'b00:   w_load = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~r_unsigned}}, w_half};
            default: w_load = w_data_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= '0;
            r_off        <= '0;
            r_mask       <= '0;
            r_col        <= '0;
            r_data       <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_rd_en      <= '0;
            r_wr_en      <= '0;
            r_lane_addr  <= '0;
            r_lane_wdata <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we         <= req_we;
                        r_unsigned   <= req_unsigned;
                        r_size       <= req_size;
                        r_off        <= req_addr[1:0];
                        r_mask       <= w_mask;
                        r_lane_addr  <= req_addr[ADDR_W-1:2];
                        r_lane_wdata <= w_wdata;
                        r_busy       <= 1'b1;
                        if (w_bad) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            // Enables are loaded here so they are high during the ISSUE cycle.
                            r_state <= S_ISSUE;
                            r_rd_en <= req_we ? 4'b0000 : w_mask;
                            r_wr_en <= req_we ? w_mask : 4'b0000;
                        end
                    end
                end
                S_ISSUE: begin
                    r_rd_en <= '0;
                    r_wr_en <= '0;
                    r_col   <= '0;
                    r_data  <= '0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_col  <= w_col_next;
                    r_data <= w_data_next;
                    if (w_col_next == r_mask) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_we ? 32'd0 : w_load;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign lane_rd_en = r_rd_en;
    assign lane_wr_en = r_wr_en;
    assign lane_addr  = r_lane_addr;
    assign lane_wdata = r_lane_wdata;
    assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-lane memory model plus a byte-addressed reference memory.
module tb_dmem_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  lane_rd_en;
    logic [3:0]  lane_wr_en;
    logic [8:0]  lane_addr;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic [3:0]  lane_valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(11)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .lane_rd_en(lane_rd_en), .lane_wr_en(lane_wr_en), .lane_addr(lane_addr),
        .lane_wdata(lane_wdata), .lane_rdata(lane_rdata), .lane_valid(lane_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Four byte lanes, one-cycle synchronous access, valid_out after read or write.
    logic [7:0]  lmem [4][512];
    logic [3:0]  lv_q = '0;
    logic [31:0] ld_q = '0;
    logic [3:0]  withhold = '0;
    logic [3:0]  inject = '0;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_rd_en[k]) ld_q[8*k +: 8] <= lmem[k][lane_addr];
            if (lane_wr_en[k]) lmem[k][lane_addr] <= lane_wdata[8*k +: 8];
        end
        lv_q <= lane_rd_en | lane_wr_en;
    end

    assign lane_rdata = ld_q;
    assign lane_valid = (lv_q & ~withhold) | inject;

    // Reference: plain byte-addressed memory, big-endian multi-byte values.
    logic [7:0] ref_mem [64];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int base_addr(input logic [1:0] sz, input int addr);
        int n = nbytes(sz);
        return addr - (addr % n);
    endfunction

    function automatic logic exp_error(input logic [1:0] sz, input int addr);
        if (sz == 2'd3) return 1'b1;
`ifdef DMEM_CTRL_ALIGN_CHK_EN
        if ((addr % nbytes(sz)) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input int addr);
        int     n = nbytes(sz);
        int     a = base_addr(sz, addr);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[a + i]);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] sz, input int addr, input logic [31:0] wd);
        int n = nbytes(sz);
        int a = base_addr(sz, addr);
        for (int i = 0; i < n; i++) ref_mem[a + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    function automatic logic [3:0] ref_lanes(input logic [1:0] sz, input int addr);
        logic [3:0] m = '0;
        int n = nbytes(sz);
        int a = base_addr(sz, addr);
        for (int i = 0; i < n; i++) m[3 - ((a + i) % 4)] = 1'b1;
        return m;
    endfunction

    // Drives one request from a negedge; returns at the negedge where resp_valid is first seen.
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [10:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err, output int lat,
                           output logic [3:0] rd_seen, output logic [3:0] wr_seen,
                           output logic [8:0] la_seen, output int en_cyc, output logic ok);
        int n;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; rd_seen = '0; wr_seen = '0; la_seen = '0; en_cyc = 0;
        while (!resp_valid && lat < 20) begin
            if ((lane_rd_en | lane_wr_en) != 4'b0000) begin en_cyc++; la_seen = lane_addr; end
            rd_seen |= lane_rd_en;
            wr_seen |= lane_wr_en;
            @(negedge clk);
            lat++;
        end
        ok = resp_valid; rd = resp_rdata; err = resp_err;
    endtask

    task automatic drain();
        resp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp got v=%b e=%b exp 0 0", resp_valid, resp_err); end
        n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        n_tests++; if (lane_rd_en !== 4'h0 || lane_wr_en !== 4'h0) begin n_fail++; $display("FAIL reset_en got rd=%b wr=%b exp 0", lane_rd_en, lane_wr_en); end
        n_tests++; if (lane_addr !== 9'h0 || lane_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_lane got a=%h d=%h exp 0", lane_addr, lane_wdata); end
    endtask

    task automatic test_prefill();
        logic [31:0] rd, wd; logic err, ok; int lat, enc; logic [3:0] rs, ws; logic [8:0] la;
        for (int a = 0; a < 64; a += 4) begin
            wd = $urandom;
            run_txn(1'b1, 2'd2, 1'b0, 11'(a), wd, rd, err, lat, rs, ws, la, enc, ok);
            drain();
            ref_store(2'd2, a, wd);
            n_tests++;
            if (!ok || err !== 1'b0 || ws !== 4'hF || la !== 9'(a / 4)) begin
                n_fail++; $display("FAIL prefill_store@%0d got ok=%b err=%b wr=%b la=%0d exp 1 0 1111 %0d", a, ok, err, ws, la, a / 4);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, exp_rd; logic err, ok; int lat, enc; logic [3:0] rs, ws; logic [8:0] la;
        run_txn(1'b1, 2'd2, 1'b0, 11'h010, 32'h12345678, rd, err, lat, rs, ws, la, enc, ok);
        ref_store(2'd2, 'h10, 32'h12345678);
        n_tests++; if (ws !== 4'b1111 || la !== 9'd4 || enc != 1) begin n_fail++; $display("FAIL st_word_lanes got wr=%b la=%0d cyc=%0d exp 1111 4 1", ws, la, enc); end
        drain();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_resp got %b exp 1", req_ready); end

        run_txn(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, rd, err, lat, rs, ws, la, enc, ok);
        n_tests++; if (!ok || rd !== 32'h12345678 || err !== 1'b0) begin n_fail++; $display("FAIL ld_word got ok=%b rd=%h err=%b exp 1 12345678 0", ok, rd, err); end
        n_tests++; if (lat != 3 || rs !== 4'b1111) begin n_fail++; $display("FAIL ld_word_timing got lat=%0d rd_en=%b exp 3 1111", lat, rs); end
        drain();

        run_txn(1'b1, 2'd0, 1'b0, 11'h013, 32'hABCDEF80, rd, err, lat, rs, ws, la, enc, ok);
        ref_store(2'd0, 'h13, 32'hABCDEF80);
        n_tests++; if (ws !== 4'b0001 || rs !== 4'b0000) begin n_fail++; $display("FAIL st_byte_lanes got wr=%b rd=%b exp 0001 0000", ws, rs); end
        drain();
        run_txn(1'b0, 2'd0, 1'b0, 11'h013, 32'h0, rd, err, lat, rs, ws, la, enc, ok);
        n_tests++; if (rd !== 32'hFFFFFF80 || err !== 1'b0) begin n_fail++; $display("FAIL ld_byte_signed got %h err=%b exp ffffff80 0", rd, err); end
        drain();
        run_txn(1'b0, 2'd0, 1'b1, 11'h013, 32'h0, rd, err, lat, rs, ws, la, enc, ok);
        n_tests++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL ld_byte_unsigned got %h exp 00000080", rd); end
        drain();

        run_txn(1'b1, 2'd1, 1'b0, 11'h022, 32'h1234BEEF, rd, err, lat, rs, ws, la, enc, ok);
        ref_store(2'd1, 'h22, 32'h1234BEEF);
        n_tests++; if (ws !== 4'b0011) begin n_fail++; $display("FAIL st_half_lanes got %b exp 0011", ws); end
        drain();
        run_txn(1'b0, 2'd1, 1'b0, 11'h022, 32'h0, rd, err, lat, rs, ws, la, enc, ok);
        n_tests++; if (rd !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL ld_half_signed got %h exp ffffbeef", rd); end
        drain();

        run_txn(1'b0, 2'd2, 1'b0, 11'h021, 32'h0, rd, err, lat, rs, ws, la, enc, ok);
`ifdef DMEM_CTRL_ALIGN_CHK_EN
        n_tests++; if (err !== 1'b1 || rd !== 32'h0 || enc != 0 || lat != 1) begin n_fail++; $display("FAIL ld_misaligned got err=%b rd=%h cyc=%0d lat=%0d exp 1 0 0 1", err, rd, enc, lat); end
`else
        exp_rd = ref_load(2'd2, 1'b0, 'h20);
        n_tests++; if (err !== 1'b0 || rd !== exp_rd || la !== 9'd8) begin n_fail++; $display("FAIL ld_misaligned got err=%b rd=%h la=%0d exp 0 %h 8", err, rd, la, exp_rd); end
`endif
        drain();
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic err, ok, bad; int lat, enc; logic [3:0] rs, ws; logic [8:0] la;
        withhold = 4'b0100;
        resp_ready = 1'b0;
        run_txn(1'b0, 2'd2, 1'b0, 11'h030, 32'h0, rd, err, lat, rs, ws, la, enc, ok);
        n_tests++; if (!ok || err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL timeout_resp got ok=%b err=%b rd=%h exp 1 1 0", ok, err, rd); end
        n_tests++; if (lat != 2 + TIMEOUT) begin n_fail++; $display("FAIL timeout_latency got %0d exp %0d", lat, 2 + TIMEOUT); end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || req_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL resp_hold got v=%b e=%b rd=%h rdy=%b exp 1 1 0 0", resp_valid, resp_err, resp_rdata, req_ready); end
        withhold = 4'b0000;
        drain();
        n_tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL resp_release got v=%b rdy=%b exp 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp_rd; logic err, ok, bad; int lat, enc; logic [3:0] rs, ws; logic [8:0] la;
        withhold = 4'hF;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 11'h010;
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++; if (lane_rd_en !== 4'hF) begin n_fail++; $display("FAIL midrst_issue got %b exp 1111", lane_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0 || resp_valid !== 1'b0 || lane_rd_en !== 4'h0 || lane_wr_en !== 4'h0) begin
            n_fail++; $display("FAIL midrst_clear got busy=%b v=%b rd=%b wr=%b exp 0 0 0 0", busy, resp_valid, lane_rd_en, lane_wr_en);
        end
        withhold = 4'h0;
        inject = 4'hF;
        @(negedge clk);
        inject = 4'h0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL midrst_late_valid got v=%b busy=%b exp 0 0", resp_valid, busy); end
        exp_rd = ref_load(2'd2, 1'b0, 'h10);
        run_txn(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, rd, err, lat, rs, ws, la, enc, ok);
        n_tests++; if (!ok || rd !== exp_rd || err !== 1'b0 || lat != 3) begin n_fail++; $display("FAIL midrst_next got rd=%h err=%b lat=%0d exp %h 0 3", rd, err, lat, exp_rd); end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, exp_rd; logic err, ok, we, uns, exp_err; int lat, enc, addr;
        logic [3:0] rs, ws, m; logic [8:0] la; logic [1:0] sz;
        for (int t = 0; t < 150; t++) begin
            we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 63); wd = $urandom;
            exp_err = exp_error(sz, addr);
            exp_rd = (exp_err || we) ? 32'h0 : ref_load(sz, uns, addr);
            m = exp_err ? 4'h0 : ref_lanes(sz, addr);
            run_txn(we, sz, uns, 11'(addr), wd, rd, err, lat, rs, ws, la, enc, ok);
            drain();
            n_tests++; if (!ok || err !== exp_err || rd !== exp_rd) begin
                n_fail++; $display("FAIL rnd_resp[%0d] we=%b sz=%0d a=%0d got ok=%b err=%b rd=%h exp 1 %b %h", t, we, sz, addr, ok, err, rd, exp_err, exp_rd);
            end
            n_tests++; if (lat != (exp_err ? 1 : 3) || enc != (exp_err ? 0 : 1)) begin
                n_fail++; $display("FAIL rnd_timing[%0d] got lat=%0d cyc=%0d exp %0d %0d", t, lat, enc, exp_err ? 1 : 3, exp_err ? 0 : 1);
            end
            n_tests++; if (rs !== (we ? 4'h0 : m) || ws !== (we ? m : 4'h0)) begin
                n_fail++; $display("FAIL rnd_lanes[%0d] got rd=%b wr=%b mask_exp=%b we=%b", t, rs, ws, m, we);
            end
            if (!exp_err) begin
                n_tests++; if (la !== 9'(base_addr(sz, addr) / 4)) begin n_fail++; $display("FAIL rnd_addr[%0d] got %0d exp %0d", t, la, base_addr(sz, addr) / 4); end
                if (we) ref_store(sz, addr, wd);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_prefill();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
